// File: rtl/mac_tx_arbiter_if.sv
// Requester-side and MAC-side AXI-Stream signals of the TX arbiter.
// The slave modport is the arbiter's view, and the master modport is the view of whatever drives it.
interface mac_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
);
   logic [NUM_REQ-1:0]    s_axis_tvalid;
   logic [NUM_REQ-1:0]    s_axis_tready;
   logic [NUM_REQ*64-1:0] s_axis_tdata;
   logic [NUM_REQ*8-1:0]  s_axis_tkeep;
   logic [NUM_REQ-1:0]    s_axis_tlast;
   logic [NUM_REQ-1:0]    s_axis_tuser;

   logic                  tx_axis_tready;
   logic                  tx_axis_tvalid;
   logic [63:0]           tx_axis_tdata;
   logic [7:0]            tx_axis_tkeep;
   logic                  tx_axis_tlast;
   logic                  tx_axis_tuser;

   modport slave (
      input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
      input  tx_axis_tready,
      output s_axis_tready,
      output tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser
   );

   modport master (
      output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
      output tx_axis_tready,
      input  s_axis_tready,
      input  tx_axis_tvalid, tx_axis_tdata, tx_axis_tkeep, tx_axis_tlast, tx_axis_tuser
   );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the MAC TX stream, with a per-packet beat watchdog.
// The data path is a zero-latency pass-through of the current grantee.
module mac_tx_arbiter #(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned MAX_BEATS = 190
) (
   input  logic                       gen_clk,
   input  logic                       sys_reset,
   input  logic                       tx_enable,
   mac_tx_arbiter_if.slave            bus,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic [31:0]                pkt_cnt,
   output logic [15:0]                trunc_cnt
);
   localparam int unsigned GW = $clog2(NUM_REQ);
   localparam int unsigned BW = $clog2(MAX_BEATS);

   typedef enum logic [1:0] {StIdle, StXfer, StDrop} state_e;

   state_e             state;
   logic [GW-1:0]      last_grant;
   logic [BW-1:0]      beat_cnt;
   logic [GW-1:0]      pick;
   logic               pick_valid;
   logic               sel_valid;
   logic               sel_last;
   logic               sel_user;
   logic [63:0]        sel_data;
   logic [7:0]         sel_keep;
   logic [NUM_REQ-1:0] rdy;
   logic               in_xfer;
   logic               wd_hit;
   logic               xfer_hs;

   // First valid requester scanning upward from last_grant+1, wrapping at NUM_REQ.
   always_comb begin : arb_pick
      int unsigned idx;
      idx        = 0;
      pick_valid = 1'b0;
      pick       = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = 32'(last_grant) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!pick_valid && bus.s_axis_tvalid[GW'(idx)]) begin
            pick_valid = 1'b1;
            pick       = GW'(idx);
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_user  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grant_id == GW'(i)) begin
            sel_valid = bus.s_axis_tvalid[i];
            sel_last  = bus.s_axis_tlast[i];
            sel_user  = bus.s_axis_tuser[i];
            sel_data  = bus.s_axis_tdata[64*i +: 64];
            sel_keep  = bus.s_axis_tkeep[8*i +: 8];
         end
      end
   end

   assign in_xfer = (state == StXfer);
   assign wd_hit  = (beat_cnt == BW'(MAX_BEATS - 1));
   assign xfer_hs = in_xfer && sel_valid && bus.tx_axis_tready;

   always_comb begin
      rdy = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grant_id == GW'(i)) begin
            rdy[i] = (in_xfer && bus.tx_axis_tready) || (state == StDrop);
         end
      end
   end

   assign bus.s_axis_tready  = rdy;
   assign bus.tx_axis_tvalid = in_xfer && sel_valid;
   assign bus.tx_axis_tdata  = in_xfer ? sel_data : '0;
   assign bus.tx_axis_tkeep  = in_xfer ? sel_keep : '0;
   // Watchdog beat is forced to end the packet and flagged as errored unless it was already the last.
   assign bus.tx_axis_tlast  = in_xfer && (sel_last || wd_hit);
   assign bus.tx_axis_tuser  = in_xfer && (sel_user || (wd_hit && !sel_last));

   always_ff @(posedge gen_clk or posedge sys_reset) begin
      if (sys_reset) begin
         state      <= StIdle;
         last_grant <= GW'(NUM_REQ - 1);
         grant_id   <= '0;
         beat_cnt   <= '0;
         busy       <= 1'b0;
         pkt_cnt    <= '0;
         trunc_cnt  <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (tx_enable && pick_valid) begin
                  grant_id <= pick;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= StXfer;
               end
            end
            StXfer: begin
               if (xfer_hs) begin
                  if (sel_last) begin
                     pkt_cnt    <= pkt_cnt + 32'd1;
                     last_grant <= grant_id;
                     busy       <= 1'b0;
                     state      <= StIdle;
                  end else if (wd_hit) begin
                     pkt_cnt <= pkt_cnt + 32'd1;
                     if (trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
                     state <= StDrop;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            StDrop: begin
               if (sel_valid && sel_last) begin
                  last_grant <= grant_id;
                  busy       <= 1'b0;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: a per-cycle vector table for single-port and fairness traffic,
// followed by hand sequences for gating, back-pressure, watchdog truncation and reset mid-packet.
module tb_mac_tx_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       en_wd;
   logic       gid;
   logic       gid_wd;
   logic       busy;
   logic       busy_wd;
   logic [31:0] pkt;
   logic [31:0] pkt_wd;
   logic [15:0] trunc;
   logic [15:0] trunc_wd;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mac_tx_arbiter_if #(.NUM_REQ(2)) bus ();
   mac_tx_arbiter_if #(.NUM_REQ(2)) bus_wd ();

   mac_tx_arbiter #(.NUM_REQ(2), .MAX_BEATS(190)) dut (
      .gen_clk   (clk),
      .sys_reset (rst),
      .tx_enable (en),
      .bus       (bus),
      .grant_id  (gid),
      .busy      (busy),
      .pkt_cnt   (pkt),
      .trunc_cnt (trunc)
   );

   mac_tx_arbiter #(.NUM_REQ(2), .MAX_BEATS(4)) dut_wd (
      .gen_clk   (clk),
      .sys_reset (rst),
      .tx_enable (en_wd),
      .bus       (bus_wd),
      .grant_id  (gid_wd),
      .busy      (busy_wd),
      .pkt_cnt   (pkt_wd),
      .trunc_cnt (trunc_wd)
   );

   typedef struct {
      logic       en;
      logic [1:0] vld;
      logic [1:0] lst;
      logic [7:0] keep;
      logic       e_vld;
      logic       e_last;
      logic [1:0] e_rdy;
      logic       e_gid;
      logic       e_busy;
      logic [7:0] e_pkt;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic v(input logic e, input logic [1:0] vl, input logic [1:0] l, input logic [7:0] k,
                    input logic ev, input logic el, input logic [1:0] er, input logic eg,
                    input logic eb, input logic [7:0] ep);
      vec_t r;
      r.en = e; r.vld = vl; r.lst = l; r.keep = k;
      r.e_vld = ev; r.e_last = el; r.e_rdy = er; r.e_gid = eg; r.e_busy = eb; r.e_pkt = ep;
      vq.push_back(r);
   endtask

   task automatic drive_main(input logic e, input logic [1:0] vl, input logic [1:0] l,
                             input logic [7:0] k, input logic [63:0] d0, input logic [63:0] d1,
                             input logic r);
      en                 = e;
      bus.s_axis_tvalid  = vl;
      bus.s_axis_tlast   = l;
      bus.s_axis_tuser   = 2'b00;
      bus.s_axis_tkeep   = {k, k};
      bus.s_axis_tdata   = {d1, d0};
      bus.tx_axis_tready = r;
   endtask

   initial begin
      int         bad;
      int         beat;
      int         n;
      int         nd;
      int         mbad;
      logic       done;
      logic       pat [4];
      logic [63:0] got [8];
      logic       mlast [8];
      logic       muser [8];

      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      rst = 1'b1;
      drive_main(1'b0, 2'b00, 2'b00, 8'h00, 64'd0, 64'd0, 1'b0);
      en_wd = 1'b0;
      bus_wd.s_axis_tvalid  = 2'b00;
      bus_wd.s_axis_tlast   = 2'b00;
      bus_wd.s_axis_tuser   = 2'b00;
      bus_wd.s_axis_tkeep   = 16'hFFFF;
      bus_wd.s_axis_tdata   = '0;
      bus_wd.tx_axis_tready = 1'b0;

      // Reset values
      #1;
      chk("rst_tvalid", 64'(bus.tx_axis_tvalid), 64'd0);
      chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_pkt", 64'(pkt), 64'd0);
      chk("rst_trunc", 64'(trunc), 64'd0);
      chk("rst_gid", 64'(gid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // Single 3-beat packet on port 0, then four back-to-back 2-beat packets on both ports
      v(1'b1, 2'b01, 2'b00, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd0);
      v(1'b1, 2'b01, 2'b00, 8'hFF, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'd0);
      v(1'b1, 2'b01, 2'b00, 8'hFF, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'd0);
      v(1'b1, 2'b01, 2'b01, 8'h0F, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 8'd0);
      v(1'b1, 2'b00, 2'b00, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd1);
      v(1'b1, 2'b11, 2'b00, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd1);
      v(1'b1, 2'b11, 2'b00, 8'hFF, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'd1);
      v(1'b1, 2'b11, 2'b10, 8'hFF, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 8'd1);
      v(1'b1, 2'b11, 2'b00, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd2);
      v(1'b1, 2'b11, 2'b00, 8'hFF, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'd2);
      v(1'b1, 2'b11, 2'b01, 8'hFF, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 8'd2);
      v(1'b1, 2'b11, 2'b00, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd3);
      v(1'b1, 2'b11, 2'b00, 8'hFF, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'd3);
      v(1'b1, 2'b11, 2'b10, 8'hFF, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 8'd3);
      v(1'b1, 2'b11, 2'b00, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'd4);
      v(1'b1, 2'b11, 2'b00, 8'hFF, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'd4);
      v(1'b1, 2'b11, 2'b01, 8'hFF, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 8'd4);
      v(1'b1, 2'b00, 2'b00, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'd5);

      foreach (vq[k]) begin
         drive_main(vq[k].en, vq[k].vld, vq[k].lst, vq[k].keep, {32'd0, 32'(k)}, {32'd1, 32'(k)},
                    1'b1);
         @(negedge clk);
         chk($sformatf("row%0d_tvalid", k), 64'(bus.tx_axis_tvalid), 64'(vq[k].e_vld));
         chk($sformatf("row%0d_rdy", k), 64'(bus.s_axis_tready), 64'(vq[k].e_rdy));
         chk($sformatf("row%0d_gid", k), 64'(gid), 64'(vq[k].e_gid));
         chk($sformatf("row%0d_busy", k), 64'(busy), 64'(vq[k].e_busy));
         chk($sformatf("row%0d_pkt", k), 64'(pkt), 64'(vq[k].e_pkt));
         if (vq[k].e_vld) begin
            chk($sformatf("row%0d_tlast", k), 64'(bus.tx_axis_tlast), 64'(vq[k].e_last));
            chk($sformatf("row%0d_tdata", k), bus.tx_axis_tdata, {31'd0, vq[k].e_gid, 32'(k)});
            chk($sformatf("row%0d_tkeep", k), 64'(bus.tx_axis_tkeep), 64'(vq[k].keep));
            chk($sformatf("row%0d_tuser", k), 64'(bus.tx_axis_tuser), 64'd0);
         end
         @(posedge clk);
         #1;
      end

      // Gating: port 1 waits 50 cycles with tx_enable low
      drive_main(1'b0, 2'b10, 2'b00, 8'hFF, 64'd0, 64'h1111, 1'b1);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.tx_axis_tvalid || (bus.s_axis_tready != 2'b00)) bad++;
         @(posedge clk);
         #1;
      end
      chk("gate_quiet", 64'(bad), 64'd0);
      en = 1'b1;
      @(negedge clk);
      chk("gate_rise_idle", 64'(bus.tx_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("gate_first_beat", 64'(bus.tx_axis_tvalid), 64'd1);
      chk("gate_gid", 64'(gid), 64'd1);
      @(posedge clk);
      #1;
      en = 1'b0;
      bus.s_axis_tlast = 2'b10;
      @(negedge clk);
      chk("gate_en_low_valid", 64'(bus.tx_axis_tvalid), 64'd1);
      chk("gate_en_low_last", 64'(bus.tx_axis_tlast), 64'd1);
      @(posedge clk);
      #1;
      drive_main(1'b1, 2'b00, 2'b00, 8'hFF, 64'd0, 64'd0, 1'b1);
      @(negedge clk);
      chk("gate_pkt", 64'(pkt), 64'd6);
      chk("gate_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      // Back-pressure: 5-beat packet on port 0 with MAC ready 1,0,0,1,...
      beat = 0; n = 0; mbad = 0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         drive_main(1'b1, 2'b01, {1'b0, beat == 4}, 8'hFF, 64'hB000 + 64'(beat), 64'd0, pat[c % 4]);
         @(negedge clk);
         if (bus.tx_axis_tvalid && (bus.s_axis_tready[0] !== bus.tx_axis_tready)) mbad++;
         if (bus.s_axis_tready[1] !== 1'b0) mbad++;
         if (bus.tx_axis_tvalid && bus.tx_axis_tready) begin
            if (n < 8) got[n] = bus.tx_axis_tdata;
            n++;
            if (beat == 4) done = 1'b1;
            beat++;
         end
         @(posedge clk);
         #1;
      end
      drive_main(1'b1, 2'b00, 2'b00, 8'hFF, 64'd0, 64'd0, 1'b1);
      chk("bp_done", 64'(done), 64'd1);
      chk("bp_count", 64'(n), 64'd5);
      chk("bp_ready_mirror", 64'(mbad), 64'd0);
      for (int i = 0; i < 5; i++) begin
         if (i < n) chk($sformatf("bp_beat%0d", i), got[i], 64'hB000 + 64'(i));
      end
      @(negedge clk);
      chk("bp_pkt", 64'(pkt), 64'd7);
      chk("bp_gid", 64'(gid), 64'd0);
      @(posedge clk);
      #1;

      // Watchdog: MAX_BEATS=4 instance, port 0 sends 7 beats before tlast
      en_wd = 1'b1;
      bus_wd.tx_axis_tready = 1'b1;
      beat = 0; n = 0; nd = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         bus_wd.s_axis_tvalid = 2'b01;
         bus_wd.s_axis_tlast  = {1'b0, beat == 6};
         bus_wd.s_axis_tdata  = {64'd0, 64'hD000 + 64'(beat)};
         @(negedge clk);
         if (bus_wd.tx_axis_tvalid) begin
            if (n < 8) begin
               got[n]   = bus_wd.tx_axis_tdata;
               mlast[n] = bus_wd.tx_axis_tlast;
               muser[n] = bus_wd.tx_axis_tuser;
            end
            n++;
         end
         if (bus_wd.s_axis_tready[0]) begin
            if (!bus_wd.tx_axis_tvalid) nd++;
            if (beat == 6) done = 1'b1;
            beat++;
         end
         @(posedge clk);
         #1;
      end
      bus_wd.s_axis_tvalid = 2'b00;
      bus_wd.s_axis_tlast  = 2'b00;
      chk("wd_done", 64'(done), 64'd1);
      chk("wd_mac_beats", 64'(n), 64'd4);
      chk("wd_dropped", 64'(nd), 64'd3);
      if (n >= 4) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("wd_beat%0d_last", i), 64'(mlast[i]), 64'd0);
            chk($sformatf("wd_beat%0d_user", i), 64'(muser[i]), 64'd0);
         end
         chk("wd_beat3_last", 64'(mlast[3]), 64'd1);
         chk("wd_beat3_user", 64'(muser[3]), 64'd1);
         chk("wd_beat3_data", got[3], 64'hD003);
      end
      @(negedge clk);
      chk("wd_trunc", 64'(trunc_wd), 64'd1);
      chk("wd_pkt", 64'(pkt_wd), 64'd1);
      chk("wd_busy", 64'(busy_wd), 64'd0);
      chk("wd_gid", 64'(gid_wd), 64'd0);
      @(posedge clk);
      #1;

      // Reset during beat 2 of a port-1 packet
      drive_main(1'b1, 2'b11, 2'b00, 8'hFF, 64'hA0, 64'hA1, 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rx_pre_gid", 64'(gid), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rx_tvalid", 64'(bus.tx_axis_tvalid), 64'd0);
      chk("rx_tlast", 64'(bus.tx_axis_tlast), 64'd0);
      chk("rx_tdata", bus.tx_axis_tdata, 64'd0);
      chk("rx_tready", 64'(bus.s_axis_tready), 64'd0);
      chk("rx_busy", 64'(busy), 64'd0);
      chk("rx_gid", 64'(gid), 64'd0);
      chk("rx_pkt", 64'(pkt), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rx_idle_after", 64'(bus.tx_axis_tvalid), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rx_first_gid", 64'(gid), 64'd0);
      chk("rx_first_valid", 64'(bus.tx_axis_tvalid), 64'd1);
      chk("rx_first_rdy", 64'(bus.s_axis_tready), 64'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
